multi_chan_data_sync: RTL and testbench

//  Multi-channel successor to the single-bus data synchroniser: NUM_CH independent

---
 rtl/data_sync_pkg.sv | 13 +
 rtl/data_sync_chan.sv | 73 +++++++
 rtl/multi_chan_data_sync.sv | 44 ++++
 tb/tb_multi_chan_data_sync.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared constants and enable-edge detection for the multi-channel data synchroniser.
// Combinational only; no flow control.
package data_sync_pkg;

   localparam int EN_MODE_LEVEL  = 0;
   localparam int EN_MODE_TOGGLE = 1;

   // Level mode reacts to a rising synced enable; toggle mode reacts to any change.
   function automatic logic edge_det(input int mode, input logic cur, input logic prev);
      return (mode == EN_MODE_TOGGLE) ? (cur ^ prev) : (cur & ~prev);
   endfunction

endpackage

// File: rtl/data_sync_chan.sv
// One channel: enable synchroniser chain, event detect, hold register, sticky overrun.
// Capture NUMB_STAGES edges after bus_en is sampled; an unconsumed word is overwritten and flagged.
module data_sync_chan
   import data_sync_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int NUMB_STAGES = 2,
   parameter int EN_MODE     = EN_MODE_LEVEL
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bus_en,
   input  logic [DATA_WIDTH-1:0] unsync_dat,
   input  logic                  sync_rdy,
   input  logic                  ovr_clr,
   output logic [DATA_WIDTH-1:0] sync_dat,
   output logic                  sync_vld,
   output logic                  en_pulse,
   output logic                  ack,
   output logic                  ovr
);

   logic [NUMB_STAGES-1:0] stage_q, stage_d;
   logic                   prev_q, prev_d;
   logic [DATA_WIDTH-1:0]  dat_q, dat_d;
   logic                   vld_q, vld_d;
   logic                   pulse_q, pulse_d;
   logic                   ovr_q, ovr_d;
   logic                   det;

   assign det = edge_det(EN_MODE, stage_q[NUMB_STAGES-1], prev_q);

   always_comb begin
      stage_d = {stage_q[NUMB_STAGES-2:0], bus_en};
      prev_d  = stage_q[NUMB_STAGES-1];
      dat_d   = dat_q;
      vld_d   = vld_q;
      pulse_d = det;
      // A fresh capture takes priority over the consumer's accept of the old word.
      if (det) begin
         dat_d = unsync_dat;
         vld_d = 1'b1;
      end else if (vld_q && sync_rdy) begin
         vld_d = 1'b0;
      end
      ovr_d = (det & vld_q & ~sync_rdy) | (ovr_q & ~ovr_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= '0;
         prev_q  <= 1'b0;
         dat_q   <= '0;
         vld_q   <= 1'b0;
         pulse_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         stage_q <= stage_d;
         prev_q  <= prev_d;
         dat_q   <= dat_d;
         vld_q   <= vld_d;
         pulse_q <= pulse_d;
         ovr_q   <= ovr_d;
      end
   end

   assign sync_dat = dat_q;
   assign sync_vld = vld_q;
   assign en_pulse = pulse_q;
   assign ack      = prev_q;
   assign ovr      = ovr_q;

endmodule

// File: rtl/multi_chan_data_sync.sv
// NUM_CH independent enable-qualified bus crossings into CLK; channel c packed at [c*DATA_WIDTH +: DATA_WIDTH].
// Latency NUMB_STAGES edges per channel; sync_valid/sync_ready hold per channel, overrun flags lost words.
module multi_chan_data_sync
   import data_sync_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CH      = 4,
   parameter int NUMB_STAGES = 2,
   parameter int EN_MODE     = EN_MODE_LEVEL
) (
   input  logic                         CLK,
   input  logic                         REST,
   input  logic [NUM_CH-1:0]            bus_en,
   input  logic [NUM_CH*DATA_WIDTH-1:0] Unsync_bus,
   input  logic [NUM_CH-1:0]            sync_ready,
   input  logic [NUM_CH-1:0]            ovr_clr,
   output logic [NUM_CH*DATA_WIDTH-1:0] Sync_bus,
   output logic [NUM_CH-1:0]            sync_valid,
   output logic [NUM_CH-1:0]            enable_pluse,
   output logic [NUM_CH-1:0]            bus_ack,
   output logic [NUM_CH-1:0]            overrun
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      data_sync_chan #(
         .DATA_WIDTH  (DATA_WIDTH),
         .NUMB_STAGES (NUMB_STAGES),
         .EN_MODE     (EN_MODE)
      ) u_chan (
         .clk        (CLK),
         .rst_n      (REST),
         .bus_en     (bus_en[c]),
         .unsync_dat (Unsync_bus[c*DATA_WIDTH +: DATA_WIDTH]),
         .sync_rdy   (sync_ready[c]),
         .ovr_clr    (ovr_clr[c]),
         .sync_dat   (Sync_bus[c*DATA_WIDTH +: DATA_WIDTH]),
         .sync_vld   (sync_valid[c]),
         .en_pulse   (enable_pluse[c]),
         .ack        (bus_ack[c]),
         .ovr        (overrun[c])
      );
   end

endmodule

// File: tb/tb_multi_chan_data_sync.sv
// Directed bench for multi_chan_data_sync: one level-mode and one toggle-mode instance, scoreboarded captures.
module tb_multi_chan_data_sync;

   logic        clk = 1'b0;
   logic        rest;
   logic [3:0]  en_l, rdy_l, clr_l, en_t, rdy_t, clr_t;
   logic [31:0] din_l, din_t;
   logic [31:0] sync_l, sync_t;
   logic [3:0]  vld_l, pulse_l, ack_l, ovr_l;
   logic [3:0]  vld_t, pulse_t, ack_t, ovr_t;

   int n_chk  = 0;
   int n_fail = 0;

   // keys 0..3 level instance channels, 4..7 toggle instance channels
   logic [7:0] exp_q [8][$];

   always #5 clk = ~clk;

   multi_chan_data_sync #(.DATA_WIDTH(8), .NUM_CH(4), .NUMB_STAGES(2), .EN_MODE(0)) dut_l (
      .CLK(clk), .REST(rest), .bus_en(en_l), .Unsync_bus(din_l), .sync_ready(rdy_l),
      .ovr_clr(clr_l), .Sync_bus(sync_l), .sync_valid(vld_l), .enable_pluse(pulse_l),
      .bus_ack(ack_l), .overrun(ovr_l));

   multi_chan_data_sync #(.DATA_WIDTH(8), .NUM_CH(4), .NUMB_STAGES(2), .EN_MODE(1)) dut_t (
      .CLK(clk), .REST(rest), .bus_en(en_t), .Unsync_bus(din_t), .sync_ready(rdy_t),
      .ovr_clr(clr_t), .Sync_bus(sync_t), .sync_valid(vld_t), .enable_pluse(pulse_t),
      .bus_ack(ack_t), .overrun(ovr_t));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mon_one(input int key, input logic [7:0] dat);
      logic [7:0] e;
      if (exp_q[key].size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL pulse_unexpected key=%0d: got data %h, expected no capture (t=%0t)", key, dat, $time);
      end else begin
         e = exp_q[key].pop_front();
         chk($sformatf("capture_data key=%0d", key), {24'h0, dat}, {24'h0, e});
      end
   endtask

   // Monitor: every capture pulse pops its channel's scoreboard entry.
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < 4; c++) begin
         if (pulse_l[c] === 1'b1) mon_one(c, sync_l[c*8 +: 8]);
         if (pulse_t[c] === 1'b1) mon_one(4 + c, sync_t[c*8 +: 8]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      rest = 1'b0;
      en_l = '0; rdy_l = '0; clr_l = '0; din_l = '0;
      en_t = '0; rdy_t = '0; clr_t = '0; din_t = '0;
      step(3);
      chk("reset sync_l", sync_l, 32'h0);
      chk("reset vld_l", {28'h0, vld_l}, 32'h0);
      chk("reset pulse_l", {28'h0, pulse_l}, 32'h0);
      chk("reset ack_l", {28'h0, ack_l}, 32'h0);
      chk("reset ovr_t", {28'h0, ovr_t}, 32'h0);
      rest = 1'b1;
      step(2);

      // 1: level capture, latency and ack
      en_l[0] = 1'b1; din_l[7:0] = 8'hA5; exp_q[0].push_back(8'hA5);
      step(1);
      chk("t1 pulse edge1", {28'h0, pulse_l}, 32'h0);
      step(1);
      chk("t1 pulse edge2", {28'h0, pulse_l}, 32'h0);
      chk("t1 ack edge2", {28'h0, ack_l}, 32'h0);
      step(1);
      chk("t1 pulse edge3", {28'h0, pulse_l}, 32'h1);
      chk("t1 sync edge3", {24'h0, sync_l[7:0]}, 32'hA5);
      chk("t1 valid edge3", {28'h0, vld_l}, 32'h1);
      chk("t1 ack edge3", {28'h0, ack_l}, 32'h1);

      // 2: accept, then held enable gives no second event
      rdy_l[0] = 1'b1;
      step(1);
      chk("t2 valid cleared", {28'h0, vld_l}, 32'h0);
      chk("t2 pulse single", {28'h0, pulse_l}, 32'h0);
      rdy_l[0] = 1'b0;
      step(20);
      chk("t2 valid after hold", {28'h0, vld_l}, 32'h0);
      chk("t2 no extra capture", exp_q[0].size(), 32'd0);
      en_l[0] = 1'b0;
      step(2);
      chk("t2 ack still high", {28'h0, ack_l}, 32'h1);
      step(1);
      chk("t2 ack fallen", {28'h0, ack_l}, 32'h0);
      step(2);

      // 4: capture and accept on the same edge
      en_l[1] = 1'b1; din_l[15:8] = 8'h33; exp_q[1].push_back(8'h33);
      step(3);
      chk("t4 first valid", {28'h0, vld_l}, 32'h2);
      en_l[1] = 1'b0;
      step(4);
      en_l[1] = 1'b1; din_l[15:8] = 8'h44; exp_q[1].push_back(8'h44);
      step(2);
      rdy_l[1] = 1'b1;
      step(1);
      rdy_l[1] = 1'b0;
      chk("t4 pulse", {28'h0, pulse_l}, 32'h2);
      chk("t4 data", {24'h0, sync_l[15:8]}, 32'h44);
      chk("t4 valid kept", {28'h0, vld_l}, 32'h2);
      chk("t4 no overrun", {28'h0, ovr_l}, 32'h0);
      rdy_l[1] = 1'b1;
      step(1);
      rdy_l[1] = 1'b0;
      chk("t4 accepted", {28'h0, vld_l}, 32'h0);
      en_l[1] = 1'b0;
      step(4);

      // 5: all channels in parallel
      din_l = 32'h04030201; en_l = 4'hF;
      for (int c = 0; c < 4; c++) exp_q[c].push_back(8'(c + 1));
      step(2);
      chk("t5 pulse edge2", {28'h0, pulse_l}, 32'h0);
      step(1);
      chk("t5 pulse all", {28'h0, pulse_l}, 32'hF);
      chk("t5 packed bus", sync_l, 32'h04030201);
      chk("t5 valid all", {28'h0, vld_l}, 32'hF);
      rdy_l = 4'hF;
      step(1);
      rdy_l = 4'h0;
      chk("t5 all accepted", {28'h0, vld_l}, 32'h0);
      en_l = 4'h0;
      step(4);

      // 3: toggle-mode overrun and clear priority
      en_t[2] = 1'b1; din_t[23:16] = 8'h11; exp_q[6].push_back(8'h11);
      step(4);
      chk("t3 first data", {24'h0, sync_t[23:16]}, 32'h11);
      chk("t3 first ovr", {28'h0, ovr_t}, 32'h0);
      en_t[2] = 1'b0; din_t[23:16] = 8'h22; exp_q[6].push_back(8'h22);
      step(3);
      chk("t3 overwrite data", {24'h0, sync_t[23:16]}, 32'h22);
      chk("t3 overrun set", {28'h0, ovr_t}, 32'h4);
      chk("t3 valid kept", {28'h0, vld_t}, 32'h4);
      clr_t[2] = 1'b1;
      step(1);
      clr_t[2] = 1'b0;
      chk("t3 overrun cleared", {28'h0, ovr_t}, 32'h0);
      en_t[2] = 1'b1; din_t[23:16] = 8'h33; exp_q[6].push_back(8'h33);
      step(2);
      clr_t[2] = 1'b1;
      step(1);
      clr_t[2] = 1'b0;
      chk("t3 set beats clear", {28'h0, ovr_t}, 32'h4);
      chk("t3 third data", {24'h0, sync_t[23:16]}, 32'h33);
      step(1);
      chk("t3 overrun sticky", {28'h0, ovr_t}, 32'h4);

      // 6: reset mid-transfer, release with enables high
      en_l = 4'h8; din_l[31:24] = 8'h5A;
      step(1);
      rest = 1'b0;
      step(1);
      chk("t6 rst sync_l", sync_l, 32'h0);
      chk("t6 rst vld_l", {28'h0, vld_l}, 32'h0);
      chk("t6 rst pulse_l", {28'h0, pulse_l}, 32'h0);
      chk("t6 rst ack_l", {28'h0, ack_l}, 32'h0);
      chk("t6 rst sync_t", sync_t, 32'h0);
      chk("t6 rst vld_t", {28'h0, vld_t}, 32'h0);
      chk("t6 rst ovr_t", {28'h0, ovr_t}, 32'h0);
      step(1);
      rest = 1'b1;
      exp_q[3].push_back(8'h5A);
      exp_q[6].push_back(8'h33);
      step(2);
      chk("t6 pulse_l early", {28'h0, pulse_l}, 32'h0);
      step(1);
      chk("t6 pulse_l after release", {28'h0, pulse_l}, 32'h8);
      chk("t6 pulse_t after release", {28'h0, pulse_t}, 32'h4);
      step(1);
      chk("t6 pulse_l single", {28'h0, pulse_l}, 32'h0);
      step(10);

      for (int k = 0; k < 8; k++)
         chk($sformatf("scoreboard drained key=%0d", k), exp_q[k].size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
